rom_load_ctrl: RTL and testbench
================================

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 4194304, cartridge byte capacity (4MB).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, packed-word FIFO entries (power of 2).
REQ-003 clk  in  1  system clock; one clock; all logic on posedge clk.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 loading  in  3  loader mode: 0 idle, 1 ROM load, 2/3 other transfers.
REQ-006 loader_do  in  8  loader byte.
REQ-007 loader_do_valid  in  1  one-cycle byte strobe.
REQ-008 mem_addr  out  21  SDRAM word address [21:1].
REQ-009 mem_din  out  16  write data, big-endian.
REQ-010 mem_be  out  2  byte enables, [1]=high byte (even address).
REQ-011 mem_req  out  1  toggle request to SDRAM port 1.
REQ-012 mem_ack  in  1  toggle acknowledge; write complete when mem_ack==mem_req.
REQ-013 md_on  out  1  core run enable (drives RESET_N of system).
REQ-014 rom_size  out  22  loaded ROM size in bytes.
REQ-015 overflow  out  1  sticky: byte dropped (FIFO full or beyond MAX_BYTES).
REQ-016 busy  out  1  high in any state other than IDLE/RUN.

Function
REQ-017 States: IDLE, LOAD, FLUSH, RUN, HOLD.
REQ-018 IDLE->LOAD when loading==1; IDLE->HOLD when loading is 2 or 3.
REQ-019 Entering LOAD: byte count, pack register, FIFO, overflow cleared; md_on=0 same cycle as transition.
REQ-020 Byte accepted only when state==LOAD, loading==1, loader_do_valid==1; otherwise ignored.
REQ-021 Byte n (0-based): even n -> pack high byte, held; odd n -> word {held, byte} pushed, be=2'b11, address n[21:1].
REQ-022 Byte with count>=MAX_BYTES SHALL be dropped, overflow=1, count not incremented.
REQ-023 Odd-byte push with FIFO full SHALL drop the word, set overflow, still increment count.
REQ-024 LOAD->FLUSH when loading!=1; if count odd, pending high byte pushed with be=2'b10 (waits one cycle for FIFO space if full).
REQ-025 Issue: when FIFO non-empty and mem_req==mem_ack, present head on mem_addr/mem_din/mem_be, toggle mem_req same cycle, pop; outputs held stable until next issue.
REQ-026 At most one outstanding request; no toggle while mem_req!=mem_ack.
REQ-027 FLUSH exits when FIFO empty and mem_req==mem_ack: rom_size=count; ->RUN with md_on=1 if loading==0, ->LOAD if loading==1, ->HOLD otherwise.
REQ-028 RUN->LOAD on loading==1; RUN->HOLD on loading 2/3; md_on=0 in HOLD.
REQ-029 HOLD->RUN (md_on=1) when loading==0 and a ROM has been loaded, else ->IDLE; HOLD->LOAD on loading==1.
REQ-030 rom_size unchanged outside FLUSH exit; address wraps never (bounded by MAX_BYTES).
REQ-031 Push and pop in same cycle SHALL both occur; FIFO occupancy unchanged.

Reset
REQ-032 On resetn==0: state IDLE, md_on=0, mem_req=0, mem_addr=0, mem_din=0, mem_be=0, rom_size=0, overflow=0, busy=0, FIFO empty, rom-loaded flag 0.
REQ-033 Reset mid-LOAD/FLUSH SHALL abandon outstanding request; mem_req restarts at 0, so SDRAM port is reset together with this block.

Structure
REQ-034 State enum and be constants (BE_WORD=2'b11, BE_HI=2'b10) SHALL live in the shared md package.
REQ-035 FIFO SHALL be one sub-module, word_fifo (data 39 bits: addr, data, be), synchronous, registered full/empty.

Verification
REQ-036 Load 4 bytes 12 34 56 78 -> writes addr0 data 1234 be 11, addr1 data 5678 be 11; rom_size=4; md_on=1 after last ack.
REQ-037 Load 3 bytes AA BB CC -> second write addr1 data CCxx be 10; rom_size=3.
REQ-038 SDRAM ack delayed 20 cycles, 16 bytes back-to-back every 2 cycles, FIFO_DEPTH 4 -> overflow=1, no extra toggles, one request outstanding max.
REQ-039 MAX_BYTES=8, load 10 bytes -> 4 writes, rom_size=8, overflow=1.
REQ-040 RUN, then loading=2 for 100 cycles with valid bytes -> md_on=0, no writes; loading=0 -> md_on=1, rom_size unchanged.
REQ-041 resetn low 1 cycle during LOAD after 5 bytes -> all outputs at reset values next cycle; fresh load of 2 bytes writes addr0.

Source files
------------

// File: rtl/rom_load_ctrl_pkg.sv
// Shared types for the cartridge ROM loader: FSM states, SDRAM byte-enable codes,
// loader mode codes and the packed FIFO word layout {addr, data, be}.
package rom_load_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN,
    ST_HOLD
  } state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_HI   = 2'b10;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_ROM  = 3'd1;

  typedef struct packed {
    logic [20:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_word_t;

  function automatic wr_word_t mk_word(input logic [20:0] addr, input logic [7:0] hi,
                                       input logic [7:0] lo, input logic [1:0] be);
    wr_word_t w;
    w.addr = addr;
    w.data = {hi, lo};
    w.be   = be;
    return w;
  endfunction

endpackage

// File: rtl/rom_load_ctrl_word_fifo.sv
// Synchronous FIFO of packed SDRAM write words; head visible combinationally, zero-latency pop.
// Full/empty are registered; a push while full or a pop while empty is ignored.
module word_fifo
  import rom_load_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_resetn,
  input  logic     i_clr,
  input  logic     i_push,
  input  wr_word_t i_dat,
  input  logic     i_pop,
  output wr_word_t o_dat,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wr_word_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_cnt_nxt;

  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && !r_empty;
  assign o_dat   = r_mem[r_rd];
  assign o_full  = r_full;
  assign o_empty = r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)
      w_cnt_nxt = r_cnt + (AW+1)'(1);
    else if (w_pop && !w_push)
      w_cnt_nxt = r_cnt - (AW+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr] <= i_dat;
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn || i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == FULL_CNT);
      r_empty <= (w_cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Packs loader bytes into big-endian 16-bit SDRAM writes and gates the core run enable.
// One toggle request outstanding at a time; bytes arriving while the FIFO is full are dropped (sticky overflow).
module rom_load_ctrl
  import rom_load_ctrl_pkg::*;
#(
  parameter int MAX_BYTES  = 4194304,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  loading,
  input  logic [7:0]  loader_do,
  input  logic        loader_do_valid,
  output logic [20:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        md_on,
  output logic [21:0] rom_size,
  output logic        overflow,
  output logic        busy
);

  localparam logic [22:0] MAX_CNT = 23'(MAX_BYTES);

  state_t      r_state;
  logic [22:0] r_cnt;
  logic [7:0]  r_hold;
  logic        r_pend;
  logic        r_ovf;
  logic        r_md_on;
  logic        r_req;
  logic [20:0] r_addr;
  logic [15:0] r_din;
  logic [1:0]  r_be;
  logic [21:0] r_rom_size;
  logic        r_loaded;

  logic        w_byte;
  logic        w_port_idle;
  logic        w_pop;
  logic        w_push;
  wr_word_t    w_push_dat;
  wr_word_t    w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_flush_done;
  logic        w_enter_load;

  assign w_byte       = (r_state == ST_LOAD) && (loading == LD_ROM) && loader_do_valid;
  assign w_port_idle  = (r_req == mem_ack);
  assign w_pop        = !w_empty && w_port_idle;
  assign w_flush_done = (r_state == ST_FLUSH) && !r_pend && w_empty && w_port_idle;
  assign w_enter_load = (loading == LD_ROM) &&
                        ((r_state == ST_IDLE) || (r_state == ST_RUN) ||
                         (r_state == ST_HOLD) || w_flush_done);

  // Odd bytes complete a word; the flush path emits a lone high byte.
  always_comb begin
    w_push     = 1'b0;
    w_push_dat = mk_word(r_cnt[21:1], r_hold, loader_do, BE_WORD);
    if (w_byte && (r_cnt < MAX_CNT) && r_cnt[0] && !w_full) begin
      w_push = 1'b1;
    end else if ((r_state == ST_FLUSH) && r_pend && !w_full) begin
      w_push     = 1'b1;
      w_push_dat = mk_word(r_cnt[21:1], r_hold, 8'h00, BE_HI);
    end
  end

  word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_clr    (w_enter_load),
    .i_push   (w_push),
    .i_dat    (w_push_dat),
    .i_pop    (w_pop),
    .o_dat    (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_pend     <= 1'b0;
      r_ovf      <= 1'b0;
      r_md_on    <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_be       <= '0;
      r_rom_size <= '0;
      r_loaded   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr <= w_head.addr;
        r_din  <= w_head.data;
        r_be   <= w_head.be;
        r_req  <= ~r_req;
      end

      if (w_flush_done) begin
        r_rom_size <= r_cnt[21:0];
        r_loaded   <= 1'b1;
      end

      if (w_enter_load) begin
        r_state <= ST_LOAD;
        r_cnt   <= '0;
        r_hold  <= '0;
        r_pend  <= 1'b0;
        r_ovf   <= 1'b0;
        r_md_on <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (loading != LD_NONE)
              r_state <= ST_HOLD;
          end
          ST_LOAD: begin
            if (loading != LD_ROM) begin
              r_state <= ST_FLUSH;
              r_pend  <= r_cnt[0];
            end else if (w_byte) begin
              if (r_cnt >= MAX_CNT) begin
                r_ovf <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 23'd1;
                if (!r_cnt[0])
                  r_hold <= loader_do;
                else if (w_full)
                  r_ovf <= 1'b1;
              end
            end
          end
          ST_FLUSH: begin
            if (r_pend && !w_full)
              r_pend <= 1'b0;
            if (w_flush_done) begin
              if (loading == LD_NONE) begin
                r_state <= ST_RUN;
                r_md_on <= 1'b1;
              end else begin
                r_state <= ST_HOLD;
              end
            end
          end
          ST_RUN: begin
            if (loading != LD_NONE) begin
              r_state <= ST_HOLD;
              r_md_on <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (loading == LD_NONE) begin
              if (r_loaded) begin
                r_state <= ST_RUN;
                r_md_on <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_addr = r_addr;
  assign mem_din  = r_din;
  assign mem_be   = r_be;
  assign mem_req  = r_req;
  assign md_on    = r_md_on;
  assign rom_size = r_rom_size;
  assign overflow = r_ovf;
  assign busy     = (r_state == ST_LOAD) || (r_state == ST_FLUSH) || (r_state == ST_HOLD);

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: a default instance and a MAX_BYTES=8 instance share stimulus,
// each with its own toggle-handshake SDRAM responder and write scoreboard.
module tb_rom_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [2:0]  loading;
  logic [7:0]  loader_do;
  logic        loader_do_valid;

  logic [20:0] mem_addr [2];
  logic [15:0] mem_din  [2];
  logic [1:0]  mem_be   [2];
  logic        mem_req  [2];
  logic        mem_ack  [2];
  logic        md_on    [2];
  logic [21:0] rom_size [2];
  logic        overflow [2];
  logic        busy     [2];

  rom_load_ctrl u_dut_a (
    .clk             (clk),
    .resetn          (resetn),
    .loading         (loading),
    .loader_do       (loader_do),
    .loader_do_valid (loader_do_valid),
    .mem_addr        (mem_addr[0]),
    .mem_din         (mem_din[0]),
    .mem_be          (mem_be[0]),
    .mem_req         (mem_req[0]),
    .mem_ack         (mem_ack[0]),
    .md_on           (md_on[0]),
    .rom_size        (rom_size[0]),
    .overflow        (overflow[0]),
    .busy            (busy[0])
  );

  rom_load_ctrl #(
    .MAX_BYTES (8)
  ) u_dut_b (
    .clk             (clk),
    .resetn          (resetn),
    .loading         (loading),
    .loader_do       (loader_do),
    .loader_do_valid (loader_do_valid),
    .mem_addr        (mem_addr[1]),
    .mem_din         (mem_din[1]),
    .mem_be          (mem_be[1]),
    .mem_req         (mem_req[1]),
    .mem_ack         (mem_ack[1]),
    .md_on           (md_on[1]),
    .rom_size        (rom_size[1]),
    .overflow        (overflow[1]),
    .busy            (busy[1])
  );

  typedef struct {
    logic [38:0] val;
    logic [38:0] mask;
  } exp_t;

  exp_t       q_a[$];
  exp_t       q_b[$];
  int         n_chk = 0;
  int         n_pass = 0;
  bit         sb_en [2];
  int         mx [2] = '{4194304, 8};
  int         bc [2];
  logic [7:0] hb [2];
  int         tog [2] = '{0, 0};
  int         viol [2] = '{0, 0};
  int         ack_dly = 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] addr_of(input int n);
    logic [31:0] t;
    t = n;
    return t[21:1];
  endfunction

  task automatic push_exp(input int d, input logic [38:0] v, input logic [38:0] m);
    exp_t e;
    e.val  = v;
    e.mask = m;
    if (sb_en[d]) begin
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
  endtask

  task automatic check_write(input int d);
    exp_t        e;
    logic [38:0] got;
    got = {mem_addr[d], mem_din[d], mem_be[d]};
    if (d == 0) begin
      chk("wr_expected_a", q_a.size() != 0, 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("wr_word_a", got & e.mask, e.val & e.mask);
      end
    end else begin
      chk("wr_expected_b", q_b.size() != 0, 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("wr_word_b", got & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic begin_load();
    loading = 3'd1;
    bc[0] = 0;
    bc[1] = 0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit model);
    loader_do       = b;
    loader_do_valid = 1'b1;
    tick();
    loader_do_valid = 1'b0;
    tick();
    if (model) begin
      for (int d = 0; d < 2; d++) begin
        if (bc[d] < mx[d]) begin
          if (bc[d] % 2 == 0) hb[d] = b;
          else push_exp(d, {addr_of(bc[d]), hb[d], b, 2'b11}, '1);
          bc[d]++;
        end
      end
    end
  endtask

  task automatic end_load();
    loading = 3'd0;
    for (int d = 0; d < 2; d++)
      if (bc[d] % 2 == 1)
        push_exp(d, {addr_of(bc[d]), hb[d], 8'h00, 2'b10}, {21'h1fffff, 8'hff, 8'h00, 2'b11});
  endtask

  task automatic wait_md(input int d, input int budget, input string tag);
    for (int i = 0; i < budget && !md_on[d]; i++)
      tick();
    chk(tag, md_on[d], 1);
  endtask

  task automatic chk_reset(input string pfx, input int d);
    chk({pfx, "_md_on"},    md_on[d],    0);
    chk({pfx, "_mem_req"},  mem_req[d],  0);
    chk({pfx, "_mem_addr"}, mem_addr[d], 0);
    chk({pfx, "_mem_din"},  mem_din[d],  0);
    chk({pfx, "_mem_be"},   mem_be[d],   0);
    chk({pfx, "_rom_size"}, rom_size[d], 0);
    chk({pfx, "_overflow"}, overflow[d], 0);
    chk({pfx, "_busy"},     busy[d],     0);
  endtask

  // SDRAM port model: acknowledge each toggle after ack_dly cycles; reset with the DUT.
  initial begin
    int cnt [2];
    cnt = '{0, 0};
    mem_ack[0] = 1'b0;
    mem_ack[1] = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        if (!resetn) begin
          mem_ack[d] = 1'b0;
          cnt[d]     = 0;
        end else if (mem_req[d] != mem_ack[d]) begin
          cnt[d]++;
          if (cnt[d] >= ack_dly) begin
            mem_ack[d] = mem_req[d];
            cnt[d]     = 0;
          end
        end
      end
    end
  end

  // Write monitor: every mem_req toggle is one write; a toggle while the previous one is unacked is a violation.
  initial begin
    logic pr [2];
    logic pa [2];
    pr = '{1'b0, 1'b0};
    pa = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!resetn) begin
          pr[d] = 1'b0;
          pa[d] = 1'b0;
        end else begin
          if (mem_req[d] != pr[d]) begin
            tog[d]++;
            if (pr[d] != pa[d]) viol[d]++;
            if (sb_en[d]) check_write(d);
          end
          pr[d] = mem_req[d];
          pa[d] = mem_ack[d];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    resetn          = 1'b0;
    loading         = 3'd0;
    loader_do       = 8'h00;
    loader_do_valid = 1'b0;
    sb_en[0]        = 1'b1;
    sb_en[1]        = 1'b0;
    tick();
    tick();
    chk_reset("rst_a", 0);
    chk_reset("rst_b", 1);
    resetn = 1'b1;
    tick();

    // Four bytes -> two full words
    begin_load();
    chk("busy_in_load", busy[0], 1);
    chk("md_off_in_load", md_on[0], 0);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    send_byte(8'h56, 1);
    send_byte(8'h78, 1);
    end_load();
    wait_md(0, 200, "md_on_4b");
    chk("ack_done_at_md_on", mem_req[0] == mem_ack[0], 1);
    chk("rom_size_4b", rom_size[0], 4);
    chk("sb_drained_4b", q_a.size(), 0);
    chk("ovf_4b", overflow[0], 0);
    chk("busy_run", busy[0], 0);

    // Odd byte count -> trailing high-byte write
    begin_load();
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 1);
    end_load();
    wait_md(0, 200, "md_on_3b");
    chk("rom_size_3b", rom_size[0], 3);
    chk("sb_drained_3b", q_a.size(), 0);

    // Slow SDRAM: FIFO overruns
    ack_dly  = 20;
    sb_en[0] = 1'b0;
    t0       = tog[0];
    begin_load();
    for (int i = 0; i < 16; i++)
      send_byte(8'(8'h40 + i), 0);
    loading = 3'd0;
    wait_md(0, 2000, "md_on_slow");
    wait_md(1, 2000, "md_on_slow_b");
    chk("ovf_slow", overflow[0], 1);
    chk("writes_lt8_slow", (tog[0] - t0) < 8, 1);
    chk("writes_ge4_slow", (tog[0] - t0) >= 4, 1);
    chk("rom_size_slow", rom_size[0], 16);
    chk("one_outstanding_a", viol[0], 0);
    chk("one_outstanding_b", viol[1], 0);

    // Size cap on the MAX_BYTES=8 instance
    ack_dly  = 1;
    sb_en[0] = 1'b1;
    sb_en[1] = 1'b1;
    begin_load();
    for (int i = 1; i <= 10; i++)
      send_byte(8'(i), 1);
    end_load();
    wait_md(0, 300, "md_on_cap_a");
    wait_md(1, 300, "md_on_cap_b");
    chk("rom_size_cap_b", rom_size[1], 8);
    chk("ovf_cap_b", overflow[1], 1);
    chk("rom_size_cap_a", rom_size[0], 10);
    chk("ovf_cap_a", overflow[0], 0);
    chk("sb_drained_cap_a", q_a.size(), 0);
    chk("sb_drained_cap_b", q_b.size(), 0);
    sb_en[1] = 1'b0;

    // Other transfer while running: hold the core, ignore bytes
    t0      = tog[0];
    loading = 3'd2;
    for (int i = 0; i < 100; i++) begin
      loader_do       = 8'($urandom_range(0, 255));
      loader_do_valid = (i % 2 == 0);
      tick();
      if (i == 3) begin
        chk("md_off_hold", md_on[0], 0);
        chk("busy_hold", busy[0], 1);
      end
    end
    loader_do_valid = 1'b0;
    chk("no_writes_hold", tog[0] - t0, 0);
    loading = 3'd0;
    tick();
    tick();
    chk("md_on_after_hold", md_on[0], 1);
    chk("rom_size_after_hold", rom_size[0], 10);

    // Reset in the middle of a load
    begin_load();
    for (int i = 0; i < 5; i++)
      send_byte(8'(8'h11 + i), 1);
    for (int i = 0; i < 10; i++)
      tick();
    chk("sb_drained_pre_rst", q_a.size(), 0);
    resetn = 1'b0;
    tick();
    chk_reset("midrst_a", 0);
    q_a.delete();
    resetn  = 1'b1;
    loading = 3'd0;
    tick();
    begin_load();
    send_byte(8'h9A, 1);
    send_byte(8'hBC, 1);
    end_load();
    wait_md(0, 200, "md_on_post_rst");
    chk("sb_drained_post_rst", q_a.size(), 0);
    chk("rom_size_post_rst", rom_size[0], 2);
    chk("addr_post_rst", mem_addr[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
